reg_bank_param: RTL and testbench
=================================

Name: reg_bank_param

Overview:
- Parametrised successor to the 32x32 datapath register bank.
- Configurable word width, depth and number of read ports. One synchronous write port.
- Built-in clear sequencer zeroes every entry after reset or on request, so no file preload is needed.
- Optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port) in the single-cycle and pipelined cores.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- wr_en  in  1  write request (RegWrite).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  combinational: this cycle's write will commit at the next clk edge.
- wr_drop  out  1  registered one-cycle pulse: the previous cycle's write was refused because the bank was busy.
- clr_req  in  1  request a full re-clear.
- busy  out  1  clear sequencer is active.

Behaviour:
- FSM states: CLEAR and READY.
  - rst asserted: state = CLEAR, ptr = 0, wr_drop = 0.
  - busy = 1 during reset and for the whole CLEAR state.
- CLEAR state:
  - Each clk edge writes 0 to entry ptr, then ptr increments.
  - On the edge that writes ptr == DEPTH-1, state -> READY.
  - busy therefore stays high for exactly DEPTH cycles after rst deasserts.
  - clr_req is ignored in CLEAR (no restart).
- READY state: clr_req = 1 -> CLEAR on the next edge with ptr = 0, and busy rises on that edge.
- Writes: wr_ack = wr_en & ~busy & ~(ZERO_REG & wr_addr == 0).
  - Commit happens on the clk edge when wr_ack = 1.
  - A write and clr_req in the same READY cycle: the write commits, then the clear overwrites it.
- wr_drop: registered as wr_en & busy. A refused write is lost, never queued.
- Reads are asynchronous/combinational; all ports are independent and any ports may share an address.
  - Any address 0 read with ZERO_REG = 1 returns 0.
  - While busy = 1, every rd_data port is forced to 0.
- rd_data reset value is 0 (busy forced). wr_ack is 0 during reset.
- ptr wraps only via state exit. It never exceeds DEPTH-1 and has width ADDR_W.
- Reset mid-CLEAR restarts the clear from ptr = 0.
- Reset mid-READY discards contents and re-clears.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined:
  - When wr_ack = 1 and rd_addr of a port equals wr_addr, that port returns wr_data in the same cycle (write-first forwarding).
  - ZERO_REG masking still has priority.
- Undefined: reads return the stored (old) value until after the commit edge.

Test Plan:
- Reset, then DEPTH = 32: release rst and count cycles.
  - Required: busy high for exactly 32 cycles.
  - Required: after busy falls, all 32 entries read 0 on both ports.
- Write 0xDEADBEEF to address 7 in READY.
  - Required: wr_ack = 1.
  - Required: next cycle, rd_addr0 = 7 and rd_addr1 = 7 both return 0xDEADBEEF.
- ZERO_REG = 1: write 0x12345678 to address 0.
  - Required: wr_ack = 0; address 0 reads 0.
  - Required: an address-5 write in the following cycle still commits.
- Assert wr_en (addr 3, 0xA5A5A5A5) two cycles after rst release.
  - Required: wr_ack = 0 and wr_drop pulses 1 for one cycle.
  - Required: after clear, address 3 reads 0.
- In READY, write 0x55 to address 9 with clr_req = 1 in the same cycle.
  - Required: busy high for 32 cycles.
  - Required: address 9 reads 0 afterwards.
  - Required: rst asserted mid-clear restarts the 32-cycle count.
- Read address 4 while writing 0x0F0F0F0F to address 4.
  - Required with REG_BANK_BYPASS_EN: 0x0F0F0F0F in the same cycle.
  - Required without REG_BANK_BYPASS_EN: the old value, then 0x0F0F0F0F the next cycle.

Source files
------------

// File: rtl/reg_bank_param.sv
// Parametrised register bank with built-in clear sequencer and N combinational read ports.
// Optional write-first forwarding to read ports when REG_BANK_BYPASS_EN is defined.
module reg_bank_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    output logic                     wr_drop,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int               DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam bit               ZR    = (ZERO_REG != 0);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign busy   = (state == CLEAR);
    assign wr_ack = wr_en & ~busy & ~(ZR & (wr_addr == '0));

    // Control state: only the sequencer and the drop flag are reset, not the storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            ptr     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            wr_drop <= wr_en & busy;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            CLEAR: begin
                if (ptr == LAST) begin
                    state_nxt = READY;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            READY: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    // A write accepted alongside clr_req lands first; the sequencer wipes it later.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_ack) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        rd_data = '0;
        ra      = '0;
        val     = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra  = rd_addr[k*ADDR_W +: ADDR_W];
            val = mem[ra];
`ifdef REG_BANK_BYPASS_EN
            if (wr_ack && (ra == wr_addr)) begin
                val = wr_data;
            end
`endif
            // Zero-register and busy masking override any forwarded data.
            if (busy || (ZR && (ra == '0))) begin
                val = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = val;
        end
    end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed self-checking bench for reg_bank_param with default parameters (32x32, 2 read ports, zero reg).
module tb_reg_bank_param;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        wr_drop;
    logic        clr_req;
    logic        busy;

    int checks = 0;
    int errors = 0;

    reg_bank_param #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_RD  (2),
        .ZERO_REG(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack (wr_ack),
        .wr_drop(wr_drop),
        .clr_req(clr_req),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one full cycle; inputs are changed and outputs sampled around the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check_val("wr_ack_on_write", {31'b0, wr_ack}, 32'd1);
        tick();
        wr_en = 1'b0;
        #1;
    endtask

    logic [31:0] exp_byp;
    int          n;

    initial begin
        rst     = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        #3 rst  = 1'b1;

        // Reset state
        tick(); tick(); tick();
        set_rd(5'd7, 5'd12);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
        #1;
        check_val("rst_busy", {31'b0, busy}, 32'd1);
        check_val("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
        check_val("rst_wr_drop", {31'b0, wr_drop}, 32'd0);
        check_val("rst_rd0", rd_data[31:0], 32'h0);
        check_val("rst_rd1", rd_data[63:32], 32'h0);
        wr_en = 1'b0;

        // Initial clear after release
        @(negedge clk);
        rst = 1'b0;
        #1;
        wait_ready(n);
        check_val("clear_len_initial", n, 32'd32);
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            #1;
            check_val("clear_rd0", rd_data[31:0], 32'h0);
            check_val("clear_rd1", rd_data[63:32], 32'h0);
        end

        // Basic write / dual-port read
        set_rd(5'd7, 5'd7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
        #1;
        check_val("w7_ack", {31'b0, wr_ack}, 32'd1);
`ifdef REG_BANK_BYPASS_EN
        exp_byp = 32'hDEAD_BEEF;
`else
        exp_byp = 32'h0;
`endif
        check_val("w7_same_cycle", rd_data[31:0], exp_byp);
        tick();
        wr_en = 1'b0;
        #1;
        check_val("w7_rd0", rd_data[31:0], 32'hDEAD_BEEF);
        check_val("w7_rd1", rd_data[63:32], 32'hDEAD_BEEF);

        // Zero register: write discarded, next write commits
        set_rd(5'd0, 5'd5);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        #1;
        check_val("z0_ack", {31'b0, wr_ack}, 32'd0);
        check_val("z0_rd_same", rd_data[31:0], 32'h0);
        tick();
        check_val("z0_drop", {31'b0, wr_drop}, 32'd0);
        do_write(5'd5, 32'h5555_AAAA);
        check_val("z0_rd_after", rd_data[31:0], 32'h0);
        check_val("a5_rd", rd_data[63:32], 32'h5555_AAAA);

        // Read during write to the same address
        do_write(5'd4, 32'h1111_2222);
        set_rd(5'd4, 5'd7);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0F0F_0F0F;
        #1;
`ifdef REG_BANK_BYPASS_EN
        exp_byp = 32'h0F0F_0F0F;
`else
        exp_byp = 32'h1111_2222;
`endif
        check_val("byp_rd_same", rd_data[31:0], exp_byp);
        check_val("byp_other_port", rd_data[63:32], 32'hDEAD_BEEF);
        tick();
        wr_en = 1'b0;
        #1;
        check_val("byp_rd_next", rd_data[31:0], 32'h0F0F_0F0F);

        // Write together with clr_req: write lands, then the clear wipes it
        set_rd(5'd9, 5'd7);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; clr_req = 1'b1;
        #1;
        check_val("clr_w_ack", {31'b0, wr_ack}, 32'd1);
        check_val("clr_busy_before", {31'b0, busy}, 32'd0);
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        #1;
        check_val("clr_busy_rise", {31'b0, busy}, 32'd1);
        check_val("clr_rd_forced", rd_data[63:32], 32'h0);
        wait_ready(n);
        check_val("clear_len_req", n, 32'd32);
        #1;
        check_val("clr_a9", rd_data[31:0], 32'h0);
        check_val("clr_a7", rd_data[63:32], 32'h0);
        set_rd(5'd4, 5'd5);
        #1;
        check_val("clr_a4", rd_data[31:0], 32'h0);
        check_val("clr_a5", rd_data[63:32], 32'h0);

        // clr_req ignored mid-clear, reset mid-clear restarts the count
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clr_req = (i == 5);
            tick();
        end
        clr_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("rst_mid_busy", {31'b0, busy}, 32'd1);
        wait_ready(n);
        check_val("clear_len_rst_mid", n, 32'd32);

        // Write refused while clearing after reset
        do_write(5'd3, 32'h3333_3333);
        set_rd(5'd3, 5'd3);
        #1;
        check_val("a3_pre", rd_data[31:0], 32'h3333_3333);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5;
        #1;
        check_val("drop_ack", {31'b0, wr_ack}, 32'd0);
        check_val("drop_pre", {31'b0, wr_drop}, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check_val("drop_pulse", {31'b0, wr_drop}, 32'd1);
        tick();
        check_val("drop_end", {31'b0, wr_drop}, 32'd0);
        wait_ready(n);
        check_val("clear_len_after_drop", n, 32'd28);
        #1;
        check_val("drop_a3", rd_data[31:0], 32'h0);
        check_val("drop_a3_p1", rd_data[63:32], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
